registered_mux_stage: RTL and testbench

Parametrised N-channel, NBits-wide selector with a registered output and a valid/ready handshake, replacing the combinational 3:1 selectors wherever a selected operand must cross a pipeline-stage boundary (forwarding paths, write-back select, PC-source select). It holds one entry, supports stall via back-pressure and bubble insertion via flush, and flags out-of-range selector codes instead of silently forcing zero.

---
 rtl/registered_mux_stage.sv | 74 +++++++
 tb/tb_registered_mux_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/registered_mux_stage.sv
// N-channel registered selector with a one-entry valid/ready output stage.
// Out-of-range selector codes register DefaultValue and are flagged and counted.
module registered_mux_stage #(
   parameter int unsigned      NBits        = 32,
   parameter int unsigned      NChannels    = 4,
   parameter int unsigned      SelBits      = 2,
   parameter logic [NBits-1:0] DefaultValue = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SelBits-1:0]         Selector,
   input  logic [NChannels*NBits-1:0] MUX_Data,
   input  logic                       In_Valid,
   output logic                       In_Ready,
   input  logic                       Flush,
   output logic                       Out_Valid,
   input  logic                       Out_Ready,
   output logic [NBits-1:0]           MUX_Output,
   output logic                       Out_Error,
   output logic                       Sel_Error,
   output logic [7:0]                 Error_Count
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state_q;
   logic             accept;
   logic             drain;
   logic             sel_oob;
   logic [NBits-1:0] sel_data;

   assign Out_Valid = (state_q == FULL);
   assign In_Ready  = !Flush && (!Out_Valid || Out_Ready);
   assign accept    = In_Valid && In_Ready;
   assign drain     = Out_Valid && Out_Ready;

   // Loop compare keeps the slice in range even when Selector can exceed NChannels-1.
   always_comb begin
      sel_data = DefaultValue;
      sel_oob  = 1'b1;
      for (int unsigned k = 0; k < NChannels; k++) begin
         if (32'(Selector) == k) begin
            sel_data = MUX_Data[k*NBits +: NBits];
            sel_oob  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         MUX_Output  <= '0;
         Out_Error   <= 1'b0;
         Sel_Error   <= 1'b0;
         Error_Count <= '0;
      end else if (Flush) begin
         state_q <= EMPTY;
      end else if (accept) begin
         state_q    <= FULL;
         MUX_Output <= sel_data;
         Out_Error  <= sel_oob;
         if (sel_oob) begin
            Sel_Error <= 1'b1;
            if (Error_Count != '1) begin
               Error_Count <= Error_Count + 8'd1;
            end
         end
      end else if (drain) begin
         state_q <= EMPTY;
      end
   end

endmodule

// File: tb/tb_registered_mux_stage.sv
// Bench for registered_mux_stage: a 4-channel and a 3-channel (default 0xDEAD)
// instance driven in lockstep and compared against a transaction-level model.
module tb_registered_mux_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   sel;
   logic [31:0]  ch [4];
   logic         in_valid, flush, out_ready;
   logic [127:0] mux_data_a;
   logic [95:0]  mux_data_b;

   logic        ready_a, valid_a, oerr_a, serr_a;
   logic [31:0] out_a;
   logic [7:0]  cnt_a;
   logic        ready_b, valid_b, oerr_b, serr_b;
   logic [31:0] out_b;
   logic [7:0]  cnt_b;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   assign mux_data_a = {ch[3], ch[2], ch[1], ch[0]};
   assign mux_data_b = {ch[2], ch[1], ch[0]};

   registered_mux_stage #(.NBits(32), .NChannels(4), .SelBits(2), .DefaultValue(32'h0)) dut_a (
      .clk(clk), .reset(rst), .Selector(sel), .MUX_Data(mux_data_a),
      .In_Valid(in_valid), .In_Ready(ready_a), .Flush(flush),
      .Out_Valid(valid_a), .Out_Ready(out_ready), .MUX_Output(out_a),
      .Out_Error(oerr_a), .Sel_Error(serr_a), .Error_Count(cnt_a)
   );

   registered_mux_stage #(.NBits(32), .NChannels(3), .SelBits(2), .DefaultValue(32'hDEAD)) dut_b (
      .clk(clk), .reset(rst), .Selector(sel), .MUX_Data(mux_data_b),
      .In_Valid(in_valid), .In_Ready(ready_b), .Flush(flush),
      .Out_Valid(valid_b), .Out_Ready(out_ready), .MUX_Output(out_b),
      .Out_Error(oerr_b), .Sel_Error(serr_b), .Error_Count(cnt_b)
   );

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic        err;
      logic        sticky;
      int unsigned cnt;
   } model_t;

   model_t ma, mb;

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_err_b;
      logic [7:0]  exp_cnt_b;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready(input model_t m);
      return !flush && (!m.valid || out_ready);
   endfunction

   // One beat per cycle: beat is taken when presented and the slot is free or leaving.
   function automatic model_t model_next(input model_t m, input int unsigned nch,
                                         input logic [31:0] def);
      model_t n;
      n = m;
      if (rst) begin
         n.valid = 1'b0; n.data = '0; n.err = 1'b0; n.sticky = 1'b0; n.cnt = 0;
      end else if (flush) begin
         n.valid = 1'b0;
      end else if (in_valid && (!m.valid || out_ready)) begin
         n.valid = 1'b1;
         if (32'(sel) < nch) begin
            n.data = ch[sel];
            n.err  = 1'b0;
         end else begin
            n.data   = def;
            n.err    = 1'b1;
            n.sticky = 1'b1;
            if (n.cnt < 255) n.cnt = n.cnt + 1;
         end
      end else if (m.valid && out_ready) begin
         n.valid = 1'b0;
      end
      return n;
   endfunction

   task automatic tick();
      #2;
      if (!rst) begin
         chk("in_ready_a", 32'(ready_a), 32'(model_ready(ma)));
         chk("in_ready_b", 32'(ready_b), 32'(model_ready(mb)));
      end
      ma = model_next(ma, 4, 32'h0);
      mb = model_next(mb, 3, 32'hDEAD);
      @(posedge clk);
      #1;
      chk("out_valid_a", 32'(valid_a), 32'(ma.valid));
      chk("mux_output_a", out_a, ma.data);
      chk("out_error_a", 32'(oerr_a), 32'(ma.err));
      chk("sel_error_a", 32'(serr_a), 32'(ma.sticky));
      chk("error_count_a", 32'(cnt_a), ma.cnt);
      chk("out_valid_b", 32'(valid_b), 32'(mb.valid));
      chk("mux_output_b", out_b, mb.data);
      chk("out_error_b", 32'(oerr_b), 32'(mb.err));
      chk("sel_error_b", 32'(serr_b), 32'(mb.sticky));
      chk("error_count_b", 32'(cnt_b), mb.cnt);
   endtask

   initial begin
      ma = '{valid: 1'b0, data: '0, err: 1'b0, sticky: 1'b0, cnt: 0};
      mb = ma;
      ch[0] = 32'hAAAA; ch[1] = 32'hBBBB; ch[2] = 32'hCCCC; ch[3] = 32'hDDDD;
      vecs[0] = '{sel: 2'd2, exp_a: 32'hCCCC, exp_b: 32'hCCCC, exp_err_b: 1'b0, exp_cnt_b: 8'd0};
      vecs[1] = '{sel: 2'd0, exp_a: 32'hAAAA, exp_b: 32'hAAAA, exp_err_b: 1'b0, exp_cnt_b: 8'd0};
      vecs[2] = '{sel: 2'd1, exp_a: 32'hBBBB, exp_b: 32'hBBBB, exp_err_b: 1'b0, exp_cnt_b: 8'd0};
      vecs[3] = '{sel: 2'd2, exp_a: 32'hCCCC, exp_b: 32'hCCCC, exp_err_b: 1'b0, exp_cnt_b: 8'd0};
      vecs[4] = '{sel: 2'd3, exp_a: 32'hDDDD, exp_b: 32'hDEAD, exp_err_b: 1'b1, exp_cnt_b: 8'd1};
      vecs[5] = '{sel: 2'd0, exp_a: 32'hAAAA, exp_b: 32'hAAAA, exp_err_b: 1'b0, exp_cnt_b: 8'd1};

      rst = 1'b1; sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      tick();
      chk("reset_valid", 32'(valid_a), 32'h0);
      chk("reset_output", out_a, 32'h0);
      chk("reset_count", 32'(cnt_b), 32'h0);
      rst = 1'b0;
      #1 chk("ready_after_reset", 32'(ready_a), 32'h1);

      // back-to-back selection, including one out-of-range beat on the 3-channel instance
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sel = vecs[i].sel;
         tick();
         chk("vec_out_a", out_a, vecs[i].exp_a);
         chk("vec_valid_a", 32'(valid_a), 32'h1);
         chk("vec_out_b", out_b, vecs[i].exp_b);
         chk("vec_err_b", 32'(oerr_b), 32'(vecs[i].exp_err_b));
         chk("vec_cnt_b", 32'(cnt_b), 32'(vecs[i].exp_cnt_b));
         chk("vec_sticky_b", 32'(serr_b), 32'(vecs[i].exp_cnt_b != 8'd0));
      end

      // stall: hold 0x1111 while 0x2222 waits upstream
      in_valid = 1'b0;
      tick();
      ch[0] = 32'h1111; sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      chk("stall_load", out_a, 32'h1111);
      ch[0] = 32'h2222;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_hold", out_a, 32'h1111);
         chk("stall_valid", 32'(valid_a), 32'h1);
         chk("stall_ready", 32'(ready_a), 32'h0);
      end
      out_ready = 1'b1;
      #1 chk("unstall_ready", 32'(ready_a), 32'h1);
      tick();
      chk("unstall_load", out_a, 32'h2222);
      chk("unstall_valid", 32'(valid_a), 32'h1);

      // flush while full blocks acceptance for one cycle
      ch[0] = 32'h3333; flush = 1'b1;
      #1 chk("flush_ready", 32'(ready_a), 32'h0);
      tick();
      chk("flush_valid", 32'(valid_a), 32'h0);
      chk("flush_hold", out_a, 32'h2222);
      flush = 1'b0;
      tick();
      chk("post_flush_load", out_a, 32'h3333);
      chk("post_flush_valid", 32'(valid_a), 32'h1);

      // error counter saturation
      sel = 2'd3;
      for (int i = 0; i < 300; i++) tick();
      chk("sat_count", 32'(cnt_b), 32'd255);
      chk("sat_sticky", 32'(serr_b), 32'h1);
      chk("sat_output", out_b, 32'hDEAD);
      sel = 2'd0;
      tick();
      chk("sat_hold_inrange", 32'(cnt_b), 32'd255);
      sel = 2'd3;
      tick();
      chk("sat_hold_oob", 32'(cnt_b), 32'd255);

      // reset while full with a beat and a flush pending
      flush = 1'b1; rst = 1'b1;
      tick();
      chk("midreset_valid", 32'(valid_b), 32'h0);
      chk("midreset_output", out_b, 32'h0);
      chk("midreset_err", 32'(oerr_b), 32'h0);
      chk("midreset_sticky", 32'(serr_b), 32'h0);
      chk("midreset_count", 32'(cnt_b), 32'h0);
      rst = 1'b0; flush = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         sel       = 2'($urandom_range(3));
         for (int k = 0; k < 4; k++) ch[k] = $urandom;
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(9) == 0);
         rst       = ($urandom_range(49) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
